// File: rtl/iso14443_2a_miller_decode_mr.sv
// Multi-rate modified-Miller decoder for the ISO/IEC 14443-2A PCD->PICC link.
// Turns end-of-pause events into SOC, data bits, EOC and error pulses.
module iso14443_2a_miller_decode_mr #(
  parameter int unsigned BASE_PERIOD = 128,
  parameter int unsigned RATE_SEL_W  = 2,
  parameter int unsigned MAX_RATE    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_n_synchronised,
  input  logic [RATE_SEL_W-1:0] rate_sel,
  output logic                  soc,
  output logic                  eoc,
  output logic                  data,
  output logic                  data_valid,
  output logic                  error,
  output logic                  active
);

  localparam int unsigned CW = $clog2(BASE_PERIOD);
  localparam int unsigned PW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_ERR_WAIT
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [RATE_SEL_W-1:0]   rate_lat, rate_nx, rate_clamped;
  logic                    prev_pause, pe;
  logic                    prev_bit, prev_bit_nx;
  logic                    z_flag, z_nx, x_flag, x_nx;
  logic                    first_sym, first_nx;
  logic                    soc_nx, eoc_nx, data_nx, dv_nx, err_nx;

  logic [PW-1:0]           t_per, q1, q3, half, cnt_w;
  logic [CW-1:0]           t_last;
  logic                    in_x, is_dec, z_eff, x_eff;

  assign rate_clamped = (rate_sel > RATE_SEL_W'(MAX_RATE)) ? RATE_SEL_W'(MAX_RATE) : rate_sel;

  assign t_per  = PW'(BASE_PERIOD) >> rate_lat;
  assign t_last = CW'(t_per - PW'(1));
  assign q1     = t_per >> 2;
  assign half   = t_per >> 1;
  assign q3     = t_per - q1;
  assign cnt_w  = {1'b0, cnt};
  assign in_x   = (cnt_w >= q1) && (cnt_w < q3);
  assign is_dec = (cnt_w == q3 - PW'(1));
  assign active = (state == S_RX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      prev_pause <= 1'b1;
      pe         <= 1'b0;
      rate_lat   <= '0;
      prev_bit   <= 1'b0;
      z_flag     <= 1'b0;
      x_flag     <= 1'b0;
      first_sym  <= 1'b0;
      soc        <= 1'b0;
      eoc        <= 1'b0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      prev_pause <= pause_n_synchronised;
      pe         <= pause_n_synchronised & ~prev_pause;
      rate_lat   <= rate_nx;
      prev_bit   <= prev_bit_nx;
      z_flag     <= z_nx;
      x_flag     <= x_nx;
      first_sym  <= first_nx;
      soc        <= soc_nx;
      eoc        <= eoc_nx;
      data       <= data_nx;
      data_valid <= dv_nx;
      error      <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    rate_nx     = rate_lat;
    prev_bit_nx = prev_bit;
    z_nx        = z_flag;
    x_nx        = x_flag;
    first_nx    = first_sym;
    soc_nx      = 1'b0;
    eoc_nx      = 1'b0;
    data_nx     = 1'b0;
    dv_nx       = 1'b0;
    err_nx      = 1'b0;
    z_eff       = z_flag | (pe & ~in_x);
    x_eff       = x_flag | (pe & in_x);

    case (state)
      S_IDLE: begin
        rate_nx = rate_clamped;
        cnt_nx  = '0;
        // an event coinciding with the eoc pulse is the tail of the old frame
        if (pe && !eoc) begin
          soc_nx      = 1'b1;
          cnt_nx      = CW'(1);
          prev_bit_nx = 1'b0;
          z_nx        = 1'b0;
          x_nx        = 1'b0;
          first_nx    = 1'b1;
          state_nx    = S_RX;
        end
      end

      S_RX: begin
        if (pe)
          cnt_nx = in_x ? (CW'(half) + CW'(1)) : CW'(1);
        else
          cnt_nx = (cnt == t_last) ? '0 : cnt + CW'(1);
        z_nx = z_eff;
        x_nx = x_eff;
        if (is_dec) begin
          z_nx     = 1'b0;
          x_nx     = 1'b0;
          first_nx = 1'b0;
          // the first decision closes the SOC symbol itself: any extra pause there is illegal
          if (first_sym) begin
            if (z_eff || x_eff) err_nx = 1'b1;
          end else if (z_eff && x_eff) begin
            err_nx = 1'b1;
          end else if (x_eff) begin
            data_nx     = 1'b1;
            dv_nx       = 1'b1;
            prev_bit_nx = 1'b1;
          end else if (z_eff) begin
            if (prev_bit) err_nx = 1'b1;
            else          dv_nx  = 1'b1;
          end else if (prev_bit) begin
            dv_nx       = 1'b1;
            prev_bit_nx = 1'b0;
          end else begin
            eoc_nx   = 1'b1;
            state_nx = S_IDLE;
          end
          if (err_nx) begin
            state_nx = S_ERR_WAIT;
            cnt_nx   = '0;
          end
        end
      end

      S_ERR_WAIT: begin
        // counter measures how long pause_n has stayed high
        if (!pause_n_synchronised) begin
          cnt_nx = '0;
        end else if (cnt == t_last) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule
